playfield_renderer: RTL and testbench

Pipelined, parametrised playfield pixel generator between the VGA timing generator and the RGB output registers. Tracks block index and in-block offset with incremental counters instead of dividers, drives the playfield memory address, and absorbs a configurable memory read latency. Colours each pixel from the cell type, applies optional per-block edge shading, and paints everything outside the playfield with a background colour.

---
 rtl/playfield_renderer.sv | 208 ++++++++++++++++++++
 tb/tb_playfield_renderer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_renderer.sv
// Playfield pixel pipeline: incremental block/offset counters, memory addressing, latency-matched
// colouring. Defining PLAYFIELD_SHADE_EN adds per-block edge highlight/shadow.

module playfield_renderer #(
   parameter int unsigned ORIGIN_H    = 40,
   parameter int unsigned ORIGIN_V    = 40,
   parameter int unsigned BLOCKS_H    = 10,
   parameter int unsigned BLOCKS_V    = 20,
   parameter int unsigned HBLK_SIZE   = 24,
   parameter int unsigned VBLK_SIZE   = 24,
   parameter int unsigned MEM_LATENCY = 1,
   parameter logic [11:0] BG_COLOR    = 12'h00F
) (
   input  logic        clk_25_175,
   input  logic        reset,
   input  logic [9:0]  hreadwire,
   input  logic [9:0]  vreadwire,
   output logic [4:0]  memselector_v,
   output logic [4:0]  memselector_h,
   input  logic [2:0]  blocktype_mem,
   output logic [11:0] pixstream
);

   localparam logic [10:0] HStart  = 11'(ORIGIN_H);
   localparam logic [10:0] HEnd    = 11'(ORIGIN_H + BLOCKS_H * HBLK_SIZE);
   localparam logic [10:0] VStart  = 11'(ORIGIN_V);
   localparam logic [10:0] VEnd    = 11'(ORIGIN_V + BLOCKS_V * VBLK_SIZE);
   localparam logic [5:0]  HOffMax = 6'(HBLK_SIZE - 1);
   localparam logic [5:0]  VOffMax = 6'(VBLK_SIZE - 1);

   logic [10:0] w_h;
   logic [10:0] w_v;
   logic        w_h_start;
   logic        w_in_h;
   logic        w_in_v;
   logic        w_in_area;
   logic [4:0]  w_h_blk;
   logic [5:0]  w_h_off;
   logic [4:0]  r_h_blk;
   logic [5:0]  r_h_off;
   logic [4:0]  r_v_blk;
   logic [5:0]  r_v_off;
   logic        r_v_sync;
   logic [4:0]  r_sel_v;
   logic [4:0]  r_sel_h;
   logic        r_s0_in_area;
   logic [MEM_LATENCY-1:0] r_dl_in_area;
   logic [11:0] w_lut;
   logic [11:0] w_pix;
   logic [11:0] r_pix;

   assign w_h       = {1'b0, hreadwire};
   assign w_v       = {1'b0, vreadwire};
   assign w_h_start = (w_h == HStart);
   assign w_in_h    = (w_h >= HStart) && (w_h < HEnd);
   assign w_in_v    = r_v_sync && (w_v >= VStart) && (w_v < VEnd);
   assign w_in_area = w_in_h && w_in_v;

   // r_h_* hold the counters of the following pixel; the origin column forces them to zero.
   assign w_h_blk = w_h_start ? 5'd0 : r_h_blk;
   assign w_h_off = w_h_start ? 6'd0 : r_h_off;

   always_ff @(posedge clk_25_175 or negedge reset) begin
      if (!reset) begin
         r_h_blk <= '0;
         r_h_off <= '0;
      end else if (w_in_h) begin
         if (w_h_off == HOffMax) begin
            r_h_off <= '0;
            r_h_blk <= w_h_blk + 5'd1;
         end else begin
            r_h_off <= w_h_off + 6'd1;
            r_h_blk <= w_h_blk;
         end
      end
   end

   always_ff @(posedge clk_25_175 or negedge reset) begin
      if (!reset) begin
         r_v_blk  <= '0;
         r_v_off  <= '0;
         r_v_sync <= 1'b0;
      end else if (hreadwire == 10'd0) begin
         if (w_v == VStart) begin
            r_v_blk  <= '0;
            r_v_off  <= '0;
            r_v_sync <= 1'b1;
         end else if ((w_v > VStart) && (w_v < VEnd)) begin
            if (r_v_off == VOffMax) begin
               r_v_off <= '0;
               r_v_blk <= r_v_blk + 5'd1;
            end else begin
               r_v_off <= r_v_off + 6'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_25_175 or negedge reset) begin
      if (!reset) begin
         r_sel_v      <= '0;
         r_sel_h      <= '0;
         r_s0_in_area <= 1'b0;
      end else begin
         r_s0_in_area <= w_in_area;
         if (w_in_area) begin
            r_sel_v <= r_v_blk;
            r_sel_h <= w_h_blk;
         end
      end
   end

   always_ff @(posedge clk_25_175 or negedge reset) begin
      if (!reset) begin
         r_dl_in_area <= '0;
      end else begin
         r_dl_in_area[0] <= r_s0_in_area;
         for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            r_dl_in_area[i] <= r_dl_in_area[i-1];
         end
      end
   end

`ifdef PLAYFIELD_SHADE_EN
   logic [5:0] r_s0_h_off;
   logic [5:0] r_s0_v_off;
   logic [MEM_LATENCY-1:0][5:0] r_dl_h_off;
   logic [MEM_LATENCY-1:0][5:0] r_dl_v_off;
   logic w_hi;
   logic w_lo;

   always_ff @(posedge clk_25_175 or negedge reset) begin
      if (!reset) begin
         r_s0_h_off <= '0;
         r_s0_v_off <= '0;
         r_dl_h_off <= '0;
         r_dl_v_off <= '0;
      end else begin
         r_s0_h_off    <= w_h_off;
         r_s0_v_off    <= r_v_off;
         r_dl_h_off[0] <= r_s0_h_off;
         r_dl_v_off[0] <= r_s0_v_off;
         for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            r_dl_h_off[i] <= r_dl_h_off[i-1];
            r_dl_v_off[i] <= r_dl_v_off[i-1];
         end
      end
   end

   assign w_hi = (r_dl_h_off[MEM_LATENCY-1] == 6'd0) || (r_dl_v_off[MEM_LATENCY-1] == 6'd0);
   assign w_lo = (r_dl_h_off[MEM_LATENCY-1] == HOffMax) || (r_dl_v_off[MEM_LATENCY-1] == VOffMax);

   function automatic logic [3:0] f_add3(input logic [3:0] n);
      return (n >= 4'hC) ? 4'hF : n + 4'd3;
   endfunction

   function automatic logic [3:0] f_sub3(input logic [3:0] n);
      return (n <= 4'h3) ? 4'h0 : n - 4'd3;
   endfunction
`endif

   always_comb begin
      w_lut = 12'h000;
      unique case (blocktype_mem)
         3'd0: w_lut = 12'h000;
         3'd1: w_lut = 12'hF00;
         3'd2: w_lut = 12'h0F0;
         3'd3: w_lut = 12'h00F;
         3'd4: w_lut = 12'hFF0;
         3'd5: w_lut = 12'hF0F;
         3'd6: w_lut = 12'h0FF;
         3'd7: w_lut = 12'hF80;
      endcase
   end

   // Empty cells stay black; highlight takes priority over shadow on corner pixels.
   always_comb begin
      w_pix = BG_COLOR;
      if (r_dl_in_area[MEM_LATENCY-1]) begin
         if (blocktype_mem == 3'd0) begin
            w_pix = 12'h000;
         end
`ifdef PLAYFIELD_SHADE_EN
         else if (w_hi) begin
            w_pix = {f_add3(w_lut[11:8]), f_add3(w_lut[7:4]), f_add3(w_lut[3:0])};
         end else if (w_lo) begin
            w_pix = {f_sub3(w_lut[11:8]), f_sub3(w_lut[7:4]), f_sub3(w_lut[3:0])};
         end
`endif
         else begin
            w_pix = w_lut;
         end
      end
   end

   always_ff @(posedge clk_25_175 or negedge reset) begin
      if (!reset) begin
         r_pix <= '0;
      end else begin
         r_pix <= w_pix;
      end
   end

   assign pixstream     = r_pix;
   assign memselector_v = r_sel_v;
   assign memselector_h = r_sel_h;

endmodule

// File: tb/tb_playfield_renderer.sv
// Directed bench for playfield_renderer: two instances (MEM_LATENCY 1 and 3) share stimulus and a
// playfield memory; outputs are captured per column at their expected latency and checked.

module tb_playfield_renderer;

   logic        clk;
   logic        rst_n;
   logic [9:0]  h;
   logic [9:0]  v;
   logic [4:0]  sel_v1, sel_h1, sel_v3, sel_h3;
   logic [2:0]  bt1, bt3;
   logic [11:0] pix1, pix3;

   int n_tests;
   int n_fail;

   logic [2:0]  mem [0:31][0:31];
   logic [2:0]  m1;
   logic [2:0]  m3 [0:2];

   logic        drv_vld;
   logic        clr_req;
   logic [9:0]  hist_h [0:4];
   logic [4:0]  hist_vld = '0;
   logic [11:0] cap1 [0:1023];
   logic [11:0] cap3 [0:1023];
   logic [4:0]  cap_sh1 [0:1023];
   logic [4:0]  cap_sv1 [0:1023];
   logic [4:0]  cap_sh3 [0:1023];

   playfield_renderer #(.MEM_LATENCY(1)) u_dut1 (
      .clk_25_175   (clk),
      .reset        (rst_n),
      .hreadwire    (h),
      .vreadwire    (v),
      .memselector_v(sel_v1),
      .memselector_h(sel_h1),
      .blocktype_mem(bt1),
      .pixstream    (pix1)
   );

   playfield_renderer #(.MEM_LATENCY(3)) u_dut3 (
      .clk_25_175   (clk),
      .reset        (rst_n),
      .hreadwire    (h),
      .vreadwire    (v),
      .memselector_v(sel_v3),
      .memselector_h(sel_h3),
      .blocktype_mem(bt3),
      .pixstream    (pix3)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Registered playfield memory with 1 and 3 cycles of read latency.
   always @(posedge clk) begin
      m1    <= mem[sel_v1][sel_h1];
      m3[0] <= mem[sel_v3][sel_h3];
      m3[1] <= m3[0];
      m3[2] <= m3[1];
   end
   assign bt1 = m1;
   assign bt3 = m3[2];

   always @(posedge clk) begin
      hist_vld  <= {hist_vld[3:0], drv_vld};
      hist_h[0] <= h;
      for (int i = 1; i < 5; i++) hist_h[i] <= hist_h[i-1];
   end

   // Selectors are due one cycle after a coordinate, pixels MEM_LATENCY+2 cycles after.
   always @(negedge clk) begin
      if (clr_req) begin
         for (int i = 0; i < 1024; i++) begin
            cap1[i]    <= 12'hBAD;
            cap3[i]    <= 12'hBAD;
            cap_sh1[i] <= 5'h1F;
            cap_sv1[i] <= 5'h1F;
            cap_sh3[i] <= 5'h1F;
         end
      end else begin
         if (hist_vld[0]) begin
            cap_sh1[hist_h[0]] <= sel_h1;
            cap_sv1[hist_h[0]] <= sel_v1;
            cap_sh3[hist_h[0]] <= sel_h3;
         end
         if (hist_vld[2]) cap1[hist_h[2]] <= pix1;
         if (hist_vld[4]) cap3[hist_h[4]] <= pix3;
      end
   end

   function automatic logic [11:0] sh(input logic [11:0] flat, input logic [11:0] shaded);
`ifdef PLAYFIELD_SHADE_EN
      return shaded;
`else
      return flat;
`endif
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      drv_vld = 1'b0;
      h       = 10'd1000;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_cap();
      clr_req = 1'b1;
      @(posedge clk);
      #1;
      clr_req = 1'b0;
   endtask

   task automatic run_line(input int vv, input int last, input bit cap);
      if (cap) clear_cap();
      for (int hh = 0; hh <= last; hh++) begin
         h       = 10'(hh);
         v       = 10'(vv);
         drv_vld = cap;
         @(posedge clk);
         #1;
      end
      idle(8);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      h       = 10'd1000;
      v       = 10'd0;
      drv_vld = 1'b0;
      clr_req = 1'b0;
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++) mem[r][c] = 3'd0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pix1", pix1, 12'h000);
      chk("rst_pix3", pix3, 12'h000);
      chk("rst_selv", {7'd0, sel_v1}, 12'd0);
      chk("rst_selh", {7'd0, sel_h1}, 12'd0);
      rst_n = 1'b1;
      idle(2);

      for (int c = 0; c < 32; c++) mem[0][c] = (c % 2 == 1) ? 3'd3 : 3'd2;

      // Not yet synchronised to a frame: background only.
      run_line(41, 299, 1'b1);
      chk("nosync_l1_c40", cap1[40], 12'h00F);
      chk("nosync_l3_c100", cap3[100], 12'h00F);

      // Frame A
      mem[0][0] = 3'd4;
      run_line(40, 299, 1'b1);
      chk("l40_c39", cap1[39], 12'h00F);
      chk("l40_c40", cap1[40], sh(12'hFF0, 12'hFF3));
      chk("l40_c63", cap1[63], sh(12'hFF0, 12'hFF3));
      chk("l40_c64", cap1[64], sh(12'h00F, 12'h33F));
      chk("l40_c280", cap1[280], 12'h00F);
      chk("l40_selh_c63", {7'd0, cap_sh1[63]}, 12'd0);
      chk("l40_selh_c64", {7'd0, cap_sh1[64]}, 12'd1);
      chk("l40_selv_c40", {7'd0, cap_sv1[40]}, 12'd0);

      mem[0][0] = 3'd2;
      run_line(41, 299, 1'b1);
      chk("l41_lat3_c39", cap3[39], 12'h00F);
      chk("l41_lat3_c40", cap3[40], sh(12'h0F0, 12'h3F3));
      chk("l41_lat3_c41", cap3[41], 12'h0F0);
      chk("l41_lat3_c63", cap3[63], sh(12'h0F0, 12'h0C0));
      chk("l41_lat3_c64", cap3[64], sh(12'h00F, 12'h33F));
      chk("l41_lat3_c65", cap3[65], 12'h00F);
      chk("l41_lat3_c279", cap3[279], sh(12'h00F, 12'h00C));
      chk("l41_lat3_c280", cap3[280], 12'h00F);
      chk("l41_lat1_c41", cap1[41], 12'h0F0);
      chk("l41_selh3_c87", {7'd0, cap_sh3[87]}, 12'd1);
      chk("l41_selh3_c88", {7'd0, cap_sh3[88]}, 12'd2);
      chk("l41_selh3_c279", {7'd0, cap_sh3[279]}, 12'd9);
      chk("l41_selh3_hold_c285", {7'd0, cap_sh3[285]}, 12'd9);

      for (int vv = 42; vv <= 49; vv++) run_line(vv, 1, 1'b0);
      mem[0][0] = 3'd4;
      run_line(50, 299, 1'b1);
      chk("l50_c52", cap1[52], 12'hFF0);
      chk("l50_c63", cap1[63], sh(12'hFF0, 12'hCC0));

      for (int vv = 51; vv <= 62; vv++) run_line(vv, 1, 1'b0);
      mem[0][1] = 3'd0;
      run_line(63, 299, 1'b1);
      chk("l63_c40_hiwins", cap1[40], sh(12'hFF0, 12'hFF3));
      chk("l63_c41_shadow", cap1[41], sh(12'hFF0, 12'hCC0));
      chk("l63_type0_c64", cap1[64], 12'h000);
      chk("l63_type0_c87", cap3[87], 12'h000);

      mem[1][0] = 3'd6;
      run_line(64, 299, 1'b1);
      chk("l64_selv_c41", {7'd0, cap_sv1[41]}, 12'd1);
      chk("l64_c41", cap1[41], sh(12'h0FF, 12'h3FF));
      chk("l64_lat3_c41", cap3[41], sh(12'h0FF, 12'h3FF));

      run_line(520, 299, 1'b1);
      chk("l520_c40", cap1[40], 12'h00F);
      chk("l520_c100", cap3[100], 12'h00F);

      // Frame B
      mem[0][0] = 3'd1;
      mem[0][1] = 3'd3;
      run_line(40, 1, 1'b0);
      run_line(41, 299, 1'b1);
      chk("fb_l41_c40", cap1[40], sh(12'hF00, 12'hF33));
      chk("fb_l41_c41", cap1[41], 12'hF00);
      chk("fb_l41_selh_c40", {7'd0, cap_sh1[40]}, 12'd0);
      chk("fb_l41_selv_c40", {7'd0, cap_sv1[40]}, 12'd0);
      chk("fb_l41_lat3_c40", cap3[40], sh(12'hF00, 12'hF33));

      // Reset asserted mid-line while playfield pixels are in flight.
      for (int hh = 0; hh <= 130; hh++) begin
         h       = 10'(hh);
         v       = 10'd42;
         drv_vld = 1'b0;
         if (hh == 100) begin
            #3;
            rst_n = 1'b0;
            #1;
            chk("async_rst_pix1", pix1, 12'h000);
            chk("async_rst_pix3", pix3, 12'h000);
            chk("async_rst_selh", {7'd0, sel_h1}, 12'd0);
         end
         @(posedge clk);
         #1;
         if (hh >= 100 && (hh % 10 == 0)) begin
            chk("rst_low_pix1", pix1, 12'h000);
            chk("rst_low_pix3", pix3, 12'h000);
         end
      end
      rst_n = 1'b1;
      idle(2);

      run_line(43, 299, 1'b1);
      chk("post_rst_c40", cap1[40], 12'h00F);
      chk("post_rst_c100", cap1[100], 12'h00F);
      chk("post_rst_c279", cap1[279], 12'h00F);
      chk("post_rst_lat3_c100", cap3[100], 12'h00F);

      run_line(40, 299, 1'b1);
      chk("resync_c41", cap1[41], sh(12'hF00, 12'hF33));
      chk("resync_lat3_c41", cap3[41], sh(12'hF00, 12'hF33));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
